tow_arbiter: RTL and testbench

- Arbitrates the two player push buttons of the tug-of-war game for the shared light-position register.
- Emits single-cycle step_l/step_r pulses to that register.
- Enforces a post-push lockout, resolves simultaneous presses fairly, and latches false starts (fouls) made while the display is dark.
- Sits between the synchronized/debounced button inputs and the position register; takes round phase from the master controller's leds_on/clr outputs and the shared slowen tick.

---
 rtl/tow_arbiter.sv | 152 +++++++++++++++
 tb/tb_tow_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tow_arbiter.sv
// Tug-of-war button arbiter: turns player presses into single-cycle step pulses
// with post-grant lockout, fair tie-breaking and false-start latching.
// Optional macro FOUL_PENALTY_EN: a side's first foul in a round steps the opponent.
module tow_arbiter #(
   parameter int unsigned LOCK_TICKS = 2,
   parameter bit          FAIR_INIT  = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pbl,
   input  logic pbr,
   input  logic leds_on,
   input  logic clr,
   input  logic slowen,
   output logic step_l,
   output logic step_r,
   output logic foul_l,
   output logic foul_r,
   output logic busy
);

   localparam int CW = (LOCK_TICKS > 0) ? $clog2(LOCK_TICKS + 1) : 1;

   typedef enum logic [1:0] {IDLE, DARK, ARMED, LOCK} state_t;

   state_t        state_q;
   logic          pbl_q, pbr_q, clr_q;
   logic          pend_l_q, pend_r_q;
   logic          ptr_q;
   logic          step_l_q, step_r_q;
   logic          foul_l_q, foul_r_q;
   logic [CW-1:0] cnt_q;
`ifdef FOUL_PENALTY_EN
   logic          pen_l_q;   // right's penalty deferred one cycle behind left's
`endif

   logic press_l, press_r, round_start;
   logic elig_l, elig_r, grant_l, grant_r, lock_done;

   assign press_l     = pbl & ~pbl_q;
   assign press_r     = pbr & ~pbr_q;
   assign round_start = clr_q & ~clr;

   assign elig_l  = (press_l | pend_l_q) & ~foul_l_q;
   assign elig_r  = (press_r | pend_r_q) & ~foul_r_q;
   assign grant_l = elig_l & (~elig_r | ~ptr_q);
   assign grant_r = elig_r & (~elig_l |  ptr_q);

   assign lock_done = (LOCK_TICKS == 0) || (slowen && (cnt_q == CW'(1)));

   // NOTE: every register here is updated with <= so all reads see the
   // pre-edge values; mixing in = would make results depend on statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pbl_q    <= 1'b0;
         pbr_q    <= 1'b0;
         clr_q    <= 1'b0;
         pend_l_q <= 1'b0;
         pend_r_q <= 1'b0;
         ptr_q    <= FAIR_INIT;
         step_l_q <= 1'b0;
         step_r_q <= 1'b0;
         foul_l_q <= 1'b0;
         foul_r_q <= 1'b0;
         cnt_q    <= '0;
`ifdef FOUL_PENALTY_EN
         pen_l_q  <= 1'b0;
`endif
      end else begin
         pbl_q    <= pbl;
         pbr_q    <= pbr;
         clr_q    <= clr;
         step_l_q <= 1'b0;
         step_r_q <= 1'b0;
`ifdef FOUL_PENALTY_EN
         pen_l_q  <= 1'b0;
`endif

         if (round_start) begin
            foul_l_q <= 1'b0;
            foul_r_q <= 1'b0;
            pend_l_q <= 1'b0;
            pend_r_q <= 1'b0;
            ptr_q    <= FAIR_INIT;
         end

         if (clr && (state_q != IDLE)) begin
            state_q <= IDLE;
         end else begin
`ifdef FOUL_PENALTY_EN
            if (pen_l_q) step_l_q <= 1'b1;
`endif
            case (state_q)
               IDLE: begin
                  if (!clr) state_q <= leds_on ? ARMED : DARK;
               end

               DARK: begin
                  if (press_l) foul_l_q <= 1'b1;
                  if (press_r) foul_r_q <= 1'b1;
`ifdef FOUL_PENALTY_EN
                  if (press_l && !foul_l_q) step_r_q <= 1'b1;
                  if (press_r && !foul_r_q) begin
                     if (press_l && !foul_l_q) pen_l_q  <= 1'b1;
                     else                      step_l_q <= 1'b1;
                  end
`endif
                  if (leds_on) state_q <= ARMED;
               end

               ARMED: begin
`ifdef FOUL_PENALTY_EN
                  // A deferred penalty owns this cycle; park any fresh claim.
                  if (pen_l_q) begin
                     if (elig_l) pend_l_q <= 1'b1;
                     if (elig_r) pend_r_q <= 1'b1;
                  end else
`endif
                  if (grant_l || grant_r) begin
                     step_l_q <= grant_l;
                     step_r_q <= grant_r;
                     if (grant_l) pend_l_q <= 1'b0;
                     else         pend_r_q <= 1'b0;
                     if (elig_l && elig_r) begin
                        ptr_q <= ~ptr_q;
                        if (grant_l) pend_r_q <= 1'b1;
                        else         pend_l_q <= 1'b1;
                     end
                     cnt_q   <= CW'(LOCK_TICKS);
                     state_q <= LOCK;
                  end
               end

               LOCK: begin
                  if (lock_done)   state_q <= ARMED;
                  else if (slowen) cnt_q   <= cnt_q - CW'(1);
               end

               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign step_l = step_l_q;
   assign step_r = step_r_q;
   assign foul_l = foul_l_q;
   assign foul_r = foul_r_q;
   assign busy   = (state_q == LOCK);

endmodule

// File: tb/tb_tow_arbiter.sv
// Scoreboard bench for tow_arbiter: directed stimulus queues expected step
// pulses (cycle and side); per-DUT monitors pop and compare each pulse seen.
module tb_tow_arbiter;

   typedef struct {
      int cyc;
      bit is_l;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pbl = 1'b0, pbr = 1'b0, pbl0 = 1'b0, pbr0 = 1'b0;
   logic leds_on = 1'b0, clr = 1'b1, slowen = 1'b0;
   logic step_l, step_r, foul_l, foul_r, busy;
   logic step_l0, step_r0, foul_l0, foul_r0, busy0;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int n0     = 0;
   exp_t q[$];
   exp_t q0[$];
   exp_t me, me0;

   tow_arbiter #(.LOCK_TICKS(2), .FAIR_INIT(1'b0)) u_dut (
      .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .leds_on(leds_on),
      .clr(clr), .slowen(slowen), .step_l(step_l), .step_r(step_r),
      .foul_l(foul_l), .foul_r(foul_r), .busy(busy)
   );

   tow_arbiter #(.LOCK_TICKS(0), .FAIR_INIT(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .pbl(pbl0), .pbr(pbr0), .leds_on(leds_on),
      .clr(clr), .slowen(slowen), .step_l(step_l0), .step_r(step_r0),
      .foul_l(foul_l0), .foul_r(foul_r0), .busy(busy0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_step(input bit is_l, input int dly);
      exp_t e;
      e.cyc  = cyc + dly;
      e.is_l = is_l;
      q.push_back(e);
   endtask

   // Two slowen ticks: with LOCK_TICKS=2 the main DUT is ARMED after the second.
   task automatic lockout();
      slowen = 1'b1; tick();
      slowen = 1'b0; tick();
      slowen = 1'b1; tick();
      slowen = 1'b0;
      check("lockout_released", busy, 0);
   endtask

   // Main DUT monitor.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
         me = q.pop_front();
         errors++; checks++;
         $display("FAIL missing_step: got none expected step_%s at cycle %0d",
                  me.is_l ? "l" : "r", me.cyc);
      end
      if (step_l || step_r) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_step: got l=%0b r=%0b expected none at cycle %0d",
                     step_l, step_r, cyc);
         end else begin
            me = q.pop_front();
            if (me.cyc != cyc || step_l != me.is_l || step_r != !me.is_l) begin
               errors++;
               $display("FAIL step_match: got l=%0b r=%0b at cycle %0d expected step_%s at cycle %0d",
                        step_l, step_r, cyc, me.is_l ? "l" : "r", me.cyc);
            end
         end
      end
   end

   // Zero-lockout DUT monitor.
   always @(negedge clk) begin
      while (q0.size() > 0 && q0[0].cyc < cyc) begin
         me0 = q0.pop_front();
         errors++; checks++;
         $display("FAIL missing_step0: got none expected step_%s at cycle %0d",
                  me0.is_l ? "l" : "r", me0.cyc);
      end
      if (step_l0 || step_r0) begin
         checks++;
         if (step_l0) n0++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL unexpected_step0: got l=%0b r=%0b expected none at cycle %0d",
                     step_l0, step_r0, cyc);
         end else begin
            me0 = q0.pop_front();
            if (me0.cyc != cyc || step_l0 != me0.is_l || step_r0 != !me0.is_l) begin
               errors++;
               $display("FAIL step_match0: got l=%0b r=%0b at cycle %0d expected step_%s at cycle %0d",
                        step_l0, step_r0, cyc, me0.is_l ? "l" : "r", me0.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by time 200000");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e0;
      // Reset state.
      tick(3);
      check("rst_step_l", step_l, 0);
      check("rst_step_r", step_r, 0);
      check("rst_foul_l", foul_l, 0);
      check("rst_foul_r", foul_r, 0);
      check("rst_busy",   busy,   0);
      rst = 1'b0; tick();

      // 1: round start dark, then lit; single press and lockout timing.
      clr = 1'b0; tick();
      leds_on = 1'b1; tick(2);
      pbl = 1'b1; expect_step(1'b1, 1); tick();
      check("t1_busy_on_step", busy, 1);
      pbl = 1'b0;
      slowen = 1'b1; tick();
      slowen = 1'b0;
      check("t1_busy_after_1st_tick", busy, 1);
      tick();
      check("t1_busy_between_ticks", busy, 1);
      slowen = 1'b1; tick();
      slowen = 1'b0;
      check("t1_armed_after_2nd_tick", busy, 0);

      // 2: tie -> left, pend right served after lockout; next tie -> right.
      pbl = 1'b1; pbr = 1'b1; expect_step(1'b1, 1); tick();
      pbl = 1'b0; pbr = 1'b0;
      lockout();
      expect_step(1'b0, 1); tick();
      check("t2_pend_served_busy", busy, 1);
      lockout();
      pbl = 1'b1; pbr = 1'b1; expect_step(1'b0, 1); tick();
      pbl = 1'b0; pbr = 1'b0;
      lockout();
      expect_step(1'b1, 1); tick();
      lockout();

      // 3: right false start in DARK.
      clr = 1'b1; tick();
      clr = 1'b0; leds_on = 1'b0; tick();
      pbr = 1'b1;
`ifdef FOUL_PENALTY_EN
      expect_step(1'b1, 1);
`endif
      tick();
      pbr = 1'b0;
      check("t3_foul_r_set", foul_r, 1);
      check("t3_foul_l_clear", foul_l, 0);
      leds_on = 1'b1; tick();
      pbr = 1'b1; tick();
      pbr = 1'b0;
      check("t3_fouled_no_lock", busy, 0);
      pbl = 1'b1; expect_step(1'b1, 1); tick();
      pbl = 1'b0;
      lockout();
      clr = 1'b1; tick();
      check("t3_foul_r_through_clr", foul_r, 1);
      clr = 1'b0; tick();
      check("t3_foul_r_cleared", foul_r, 0);
      pbr = 1'b1; expect_step(1'b0, 1); tick();
      pbr = 1'b0;
      lockout();

      // 4: zero-lockout DUT, left held 50 cycles -> one step.
      n0 = 0;
      pbl0 = 1'b1;
      e0.cyc = cyc + 1; e0.is_l = 1'b1; q0.push_back(e0);
      tick(50);
      pbl0 = 1'b0; tick(2);
      check("t4_single_step_held", n0, 1);
      check("t4_busy0_released", busy0, 0);

      // 5: clr during LOCK with pend_l set; then reset during LOCK.
      pbl = 1'b1; pbr = 1'b1; expect_step(1'b1, 1); tick();
      pbl = 1'b0; pbr = 1'b0;
      lockout();
      expect_step(1'b0, 1); tick();
      lockout();
      pbl = 1'b1; pbr = 1'b1; expect_step(1'b0, 1); tick();
      pbl = 1'b0; pbr = 1'b0;
      check("t5_in_lock", busy, 1);
      clr = 1'b1; tick();
      check("t5_clr_to_idle", busy, 0);
      tick(2);
      clr = 1'b0; tick(4);
      check("t5_pend_dropped_armed", busy, 0);
      pbl = 1'b1; expect_step(1'b1, 1); tick();
      pbl = 1'b0;
      check("t5_lock_before_rst", busy, 1);
      rst = 1'b1; tick();
      check("t5_rst_step_l", step_l, 0);
      check("t5_rst_step_r", step_r, 0);
      check("t5_rst_foul_l", foul_l, 0);
      check("t5_rst_foul_r", foul_r, 0);
      check("t5_rst_busy",   busy,   0);
      rst = 1'b0; tick(2);

      // 6: left fouls twice in DARK; then both foul together.
      clr = 1'b1; tick();
      clr = 1'b0; leds_on = 1'b0; tick();
      pbl = 1'b1;
`ifdef FOUL_PENALTY_EN
      expect_step(1'b0, 1);
`endif
      tick();
      pbl = 1'b0; tick();
      pbl = 1'b1; tick();
      pbl = 1'b0;
      check("t6_foul_l_set", foul_l, 1);
      check("t6_foul_r_clear", foul_r, 0);
      tick(2);
      clr = 1'b1; tick();
      clr = 1'b0; tick();
      check("t6_foul_l_new_round", foul_l, 0);
      pbl = 1'b1; pbr = 1'b1;
`ifdef FOUL_PENALTY_EN
      expect_step(1'b0, 1);
      expect_step(1'b1, 2);
`endif
      tick();
      pbl = 1'b0; pbr = 1'b0;
      check("t6_both_foul_l", foul_l, 1);
      check("t6_both_foul_r", foul_r, 1);
      tick(2);
      leds_on = 1'b1; tick();
      pbl = 1'b1; tick();
      pbl = 1'b0; tick(3);
      check("t6_fouled_left_no_lock", busy, 0);

      check("scoreboard_drained", q.size(), 0);
      check("scoreboard0_drained", q0.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
